// File: rtl/lru_bits_unit.sv
// Pairwise-age LRU helper for one 4-way set: registers the pre-update victim
// way and the state with the accessed way promoted to most-recently-used.
module lru_bits_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic [5:0] LRU_in,
    input  logic [1:0] Way,
    output logic [1:0] LRU,
    output logic [5:0] LRU_out
);

    logic [1:0] r_lru;
    logic [5:0] r_lru_out;
    logic [1:0] w_victim;
    logic [5:0] w_next;
    logic [3:0] w_is_lru;

    // Way w is LRU when every other way is newer: bit(w,j)=0 for j>w, bit(i,w)=1 for i<w.
    function automatic logic [3:0] lru_candidates(input logic [5:0] s);
        logic [3:0] c;
        c[0] = ~s[0] & ~s[1] & ~s[2];
        c[1] =  s[0] & ~s[3] & ~s[4];
        c[2] =  s[1] &  s[3] & ~s[5];
        c[3] =  s[2] &  s[4] &  s[5];
        return c;
    endfunction

    // Lowest-index candidate wins; a cyclic state with no candidate falls back to way 0.
    function automatic logic [1:0] pick_victim(input logic [3:0] c);
        logic [1:0] v;
        if (c[0]) begin
            v = 2'd0;
        end else if (c[1]) begin
            v = 2'd1;
        end else if (c[2]) begin
            v = 2'd2;
        end else if (c[3]) begin
            v = 2'd3;
        end else begin
            v = 2'd0;
        end
        return v;
    endfunction

    // Promote way w: it becomes newer than every other way; unrelated pairs pass through.
    function automatic logic [5:0] promote(input logic [5:0] s, input logic [1:0] w);
        logic [5:0] n;
        n = s;
        case (w)
            2'd0: begin
                n[0] = 1'b1;
                n[1] = 1'b1;
                n[2] = 1'b1;
            end
            2'd1: begin
                n[0] = 1'b0;
                n[3] = 1'b1;
                n[4] = 1'b1;
            end
            2'd2: begin
                n[1] = 1'b0;
                n[3] = 1'b0;
                n[5] = 1'b1;
            end
            2'd3: begin
                n[2] = 1'b0;
                n[4] = 1'b0;
                n[5] = 1'b0;
            end
            default: begin
                n = s;
            end
        endcase
        return n;
    endfunction

    // Next-value logic evaluated on the pre-update state.
    always_comb begin
        w_is_lru = 4'd0;
        w_victim = 2'd0;
        w_next   = 6'd0;
        w_is_lru = lru_candidates(LRU_in);
        w_victim = pick_victim(w_is_lru);
        w_next   = promote(LRU_in, Way);
    end

    // Output registers: load on go, otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lru     <= 2'd0;
            r_lru_out <= 6'd0;
        end else if (go) begin
            r_lru     <= w_victim;
            r_lru_out <= w_next;
        end else begin
            r_lru     <= r_lru;
            r_lru_out <= r_lru_out;
        end
    end

    assign LRU     = r_lru;
    assign LRU_out = r_lru_out;

endmodule

// File: tb/tb_lru_bits_unit.sv
// Self-checking bench for lru_bits_unit: directed scenarios, hold, reset,
// exhaustive sweep and random traffic against an age-relation model.
module tb_lru_bits_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       go;
    logic [5:0] LRU_in;
    logic [1:0] Way;
    logic [1:0] LRU;
    logic [5:0] LRU_out;

    int errors = 0;
    int checks = 0;
    logic [1:0] exp_lru;
    logic [5:0] exp_out;

    lru_bits_unit dut (
        .clk     (clk),
        .reset   (reset),
        .go      (go),
        .LRU_in  (LRU_in),
        .Way     (Way),
        .LRU     (LRU),
        .LRU_out (LRU_out)
    );

    always #5 clk = ~clk;

    // Position of pair (i,j), i<j, when pairs are listed in lexical order.
    function automatic int pair_pos(input int i, input int j);
        int p = 0;
        for (int a = 0; a < 4; a++) begin
            for (int b = a + 1; b < 4; b++) begin
                if (a == i && b == j) return p;
                p++;
            end
        end
        return 0;
    endfunction

    // True when way a was used more recently than way b.
    function automatic bit newer(input logic [5:0] s, input int a, input int b);
        if (a < b) return s[pair_pos(a, b)] == 1'b1;
        return s[pair_pos(b, a)] == 1'b0;
    endfunction

    // LRU = the lowest way that every other way is newer than; none found -> 0.
    function automatic logic [1:0] model_victim(input logic [5:0] s);
        for (int w = 0; w < 4; w++) begin
            bit ok = 1'b1;
            for (int o = 0; o < 4; o++) begin
                if (o != w && newer(s, w, o)) ok = 1'b0;
            end
            if (ok) return 2'(w);
        end
        return 2'd0;
    endfunction

    function automatic logic [5:0] model_update(input logic [5:0] s, input int w);
        logic [5:0] r = s;
        for (int a = 0; a < 4; a++) begin
            for (int b = a + 1; b < 4; b++) begin
                if (a == w) r[pair_pos(a, b)] = 1'b1;
                else if (b == w) r[pair_pos(a, b)] = 1'b0;
            end
        end
        return r;
    endfunction

    // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic apply(input logic g, input logic [5:0] s, input logic [1:0] w);
        @(negedge clk);
        go = g;
        LRU_in = s;
        Way = w;
        if (g) begin
            exp_lru = model_victim(s);
            exp_out = model_update(s, int'(w));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        go = 1'b1;
        LRU_in = 6'b111111;
        Way = 2'd3;
        #2;
        checks++;
        if (LRU !== 2'd0 || LRU_out !== 6'd0) begin
            errors++;
            $display("FAIL reset_initial: LRU=%0d LRU_out=%b, expected 0 and 000000", LRU, LRU_out);
        end
        @(posedge clk);
        #1;
        checks++;
        if (LRU !== 2'd0 || LRU_out !== 6'd0) begin
            errors++;
            $display("FAIL reset_over_go: LRU=%0d LRU_out=%b, expected 0 and 000000", LRU, LRU_out);
        end
        @(negedge clk);
        reset = 1'b0;
        go = 1'b0;
        exp_lru = 2'd0;
        exp_out = 6'd0;
    endtask

    task automatic test_directed;
        logic [5:0] ins [4] = '{6'b000000, 6'b000111, 6'b011110, 6'b001001};
        logic [1:0] ways[4] = '{2'd0, 2'd1, 2'd3, 2'd2};
        logic [1:0] el  [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
        logic [5:0] eo  [4] = '{6'b000111, 6'b011110, 6'b001010, 6'b100001};
        for (int k = 0; k < 4; k++) begin
            apply(1'b1, ins[k], ways[k]);
            checks++;
            if (LRU !== el[k]) begin
                errors++;
                $display("FAIL directed_lru[%0d]: got %0d, expected %0d", k, LRU, el[k]);
            end
            checks++;
            if (LRU_out !== eo[k]) begin
                errors++;
                $display("FAIL directed_out[%0d]: got %b, expected %b", k, LRU_out, eo[k]);
            end
        end
    endtask

    task automatic test_hold;
        apply(1'b1, 6'b000111, 2'd1);
        for (int k = 0; k < 6; k++) begin
            apply(1'b0, 6'($urandom), 2'($urandom));
            checks++;
            if (LRU !== 2'd1 || LRU_out !== 6'b011110) begin
                errors++;
                $display("FAIL hold[%0d]: LRU=%0d LRU_out=%b, expected 1 and 011110", k, LRU, LRU_out);
            end
        end
    endtask

    task automatic test_reset_mid;
        apply(1'b1, 6'b000000, 2'd0);
        @(negedge clk);
        #2;
        go = 1'b1;
        LRU_in = 6'b011110;
        Way = 2'd3;
        reset = 1'b1;
        #1;
        checks++;
        if (LRU !== 2'd0 || LRU_out !== 6'd0) begin
            errors++;
            $display("FAIL reset_async: LRU=%0d LRU_out=%b, expected 0 and 000000", LRU, LRU_out);
        end
        @(posedge clk);
        #1;
        checks++;
        if (LRU !== 2'd0 || LRU_out !== 6'd0) begin
            errors++;
            $display("FAIL reset_discard: LRU=%0d LRU_out=%b, expected 0 and 000000", LRU, LRU_out);
        end
        @(negedge clk);
        reset = 1'b0;
        apply(1'b1, 6'b011110, 2'd3);
        checks++;
        if (LRU !== 2'd2 || LRU_out !== 6'b001010) begin
            errors++;
            $display("FAIL first_after_reset: LRU=%0d LRU_out=%b, expected 2 and 001010", LRU, LRU_out);
        end
    endtask

    task automatic test_sweep;
        for (int s = 0; s < 64; s++) begin
            for (int w = 0; w < 4; w++) begin
                apply(1'b1, 6'(s), 2'(w));
                checks++;
                if (LRU !== exp_lru || LRU_out !== exp_out) begin
                    errors++;
                    $display("FAIL sweep in=%b way=%0d: LRU=%0d LRU_out=%b, expected %0d and %b",
                             6'(s), w, LRU, LRU_out, exp_lru, exp_out);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        for (int k = 0; k < 200; k++) begin
            apply(1'($urandom_range(0, 1)), 6'($urandom), 2'($urandom));
            checks++;
            if (LRU !== exp_lru || LRU_out !== exp_out) begin
                errors++;
                $display("FAIL random[%0d] go=%0d in=%b way=%0d: LRU=%0d LRU_out=%b, expected %0d and %b",
                         k, go, LRU_in, Way, LRU, LRU_out, exp_lru, exp_out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_reset_mid();
        test_sweep();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
